// File: rtl/expr_bus_pkg.sv
// Shared definitions for the 90-bit packed expression-result bus {y0..y17}.
// Field i is 4 + (i%3) bits wide and is signed when (i/3) is odd.
package expr_bus_pkg;

    localparam int unsigned NUM_FIELDS = 18;
    localparam int unsigned PACKED_W   = 90;
    localparam int unsigned FIELD_W    = 6;
    localparam int unsigned IDX_W      = 5;
    localparam int unsigned WIDTH_W    = 3;
    localparam int unsigned SUM_W      = 12;

    typedef logic [IDX_W-1:0]   field_idx_t;
    typedef logic [WIDTH_W-1:0] field_width_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } unpack_state_t;

    localparam field_idx_t LAST_IDX = field_idx_t'(NUM_FIELDS - 1);

    // Bit width of field idx: 4, 5 or 6, repeating.
    function automatic field_width_t field_width(input field_idx_t idx);
        return WIDTH_W'(4) + WIDTH_W'(idx % IDX_W'(3));
    endfunction

    // Field idx is signed when its group of three has an odd index.
    function automatic logic field_signed(input field_idx_t idx);
        return 1'(idx / IDX_W'(3));
    endfunction

endpackage

// File: rtl/expr_field_extend.sv
// Extends a top-aligned raw field of 4..6 bits to FIELD_W bits.
// i_raw holds the field in its most significant bits; unused low bits are ignored.
module expr_field_extend
    import expr_bus_pkg::*;
(
    input  logic [FIELD_W-1:0] i_raw,
    input  field_width_t       i_width,
    input  logic               i_signed,
    output logic [FIELD_W-1:0] o_value_c
);

    // Right-align the field and fill the upper bits with sign or zero.
    always_comb begin
        o_value_c = '0;
        case (i_width)
            WIDTH_W'(4): o_value_c = {{2{i_signed & i_raw[5]}}, i_raw[5:2]};
            WIDTH_W'(5): o_value_c = {i_signed & i_raw[5], i_raw[5:1]};
            default:     o_value_c = i_raw;
        endcase
    end

endmodule

// File: rtl/expr_result_unpacker.sv
// Receives one packed 90-bit expression-result vector per handshake and streams
// its 18 fields out one per beat, each extended to FIELD_W bits.
// Optional build macro EXPR_UNPACK_SUM_EN adds a signed full-vector sum output.
module expr_result_unpacker
    import expr_bus_pkg::*;
#(
    parameter bit BACK_TO_BACK = 1'b1
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PACKED_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output field_idx_t          out_idx,
    output logic [FIELD_W-1:0]  out_field,
    output logic                out_last
`ifdef EXPR_UNPACK_SUM_EN
    ,
    output logic                sum_valid,
    output logic [SUM_W-1:0]    sum_data
`endif
);

    unpack_state_t       r_state;
    unpack_state_t       w_state_nxt;
    logic [PACKED_W-1:0] r_shift;
    logic [PACKED_W-1:0] w_shift_nxt;
    field_idx_t          r_idx;
    field_idx_t          w_idx_nxt;

    field_width_t        w_width;
    logic                w_signed;
    logic                w_is_last;
    logic                w_out_hs;
    logic                w_in_hs;

    assign w_width   = field_width(r_idx);
    assign w_signed  = field_signed(r_idx);
    assign w_is_last = (r_idx == LAST_IDX);

    assign out_valid = (r_state == EMIT);
    assign out_idx   = r_idx;
    assign out_last  = out_valid && w_is_last;
    assign in_ready  = (r_state == IDLE) || (BACK_TO_BACK && out_last && out_ready);

    assign w_out_hs  = out_valid && out_ready;
    assign w_in_hs   = in_valid && in_ready;

    // Current field sits in the top bits of the shift register.
    expr_field_extend u_extend (
        .i_raw     (r_shift[PACKED_W-1 -: FIELD_W]),
        .i_width   (w_width),
        .i_signed  (w_signed),
        .o_value_c (out_field)
    );

    // Next-state logic: load on input handshake, shift out one field per beat.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (w_in_hs) begin
                    w_state_nxt = EMIT;
                    w_shift_nxt = in_data;
                    w_idx_nxt   = '0;
                end
            end
            EMIT: begin
                if (w_out_hs) begin
                    if (w_is_last) begin
                        if (w_in_hs) begin
                            w_shift_nxt = in_data;
                            w_idx_nxt   = '0;
                        end else begin
                            w_state_nxt = IDLE;
                            w_idx_nxt   = '0;
                        end
                    end else begin
                        w_shift_nxt = r_shift << w_width;
                        w_idx_nxt   = r_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // State, shift register and field index; reset drops any partial vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

`ifdef EXPR_UNPACK_SUM_EN
    logic [SUM_W-1:0] r_acc;
    logic [SUM_W-1:0] r_sum_data;
    logic             r_sum_valid;
    logic [SUM_W-1:0] w_field_wide;
    logic [SUM_W-1:0] w_acc_sum;

    assign w_field_wide = {{(SUM_W-FIELD_W){w_signed & out_field[FIELD_W-1]}}, out_field};
    assign w_acc_sum    = r_acc + w_field_wide;
    assign sum_valid    = r_sum_valid;
    assign sum_data     = r_sum_data;

    // Running sum per vector; result published the cycle after the last beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_sum_data  <= '0;
            r_sum_valid <= 1'b0;
        end else begin
            r_sum_valid <= w_out_hs && w_is_last;
            if (w_out_hs && w_is_last) begin
                r_sum_data <= w_acc_sum;
            end
            if (w_in_hs) begin
                r_acc <= '0;
            end else if (w_out_hs) begin
                r_acc <= w_acc_sum;
            end
        end
    end
`endif

endmodule
